// File: rtl/ysyx_23060201_exu_mc_if.sv
// Bundle between the multi-cycle EXU and its neighbours: the IDU issue handshake,
// the WBU result handshake and the req/rsp data-memory port.
interface ysyx_23060201_exu_mc_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int MASK_WIDTH = DATA_WIDTH / 8;

   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_pc;
   logic [DATA_WIDTH-1:0] in_imm;
   logic [6:0]            in_op;
   logic [4:0]            in_rd;
   logic [2:0]            in_func3;
   logic [6:0]            in_func7;
   logic [DATA_WIDTH-1:0] in_rs1;
   logic [DATA_WIDTH-1:0] in_rs2;

   logic                  out_valid;
   logic                  out_ready;
   logic                  gpr_wen;
   logic [4:0]            gpr_waddr;
   logic [DATA_WIDTH-1:0] gpr_wdata;
   logic                  jump_en;
   logic [ADDR_WIDTH-1:0] dnpc;
   logic                  exc_misalign;

   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic                  mem_req_wen;
   logic [ADDR_WIDTH-1:0] mem_req_addr;
   logic [DATA_WIDTH-1:0] mem_req_wdata;
   logic [MASK_WIDTH-1:0] mem_req_wmask;
   logic                  mem_rsp_valid;
   logic [DATA_WIDTH-1:0] mem_rsp_rdata;

   // EXU side
   modport slave (
      input  in_valid, in_pc, in_imm, in_op, in_rd, in_func3, in_func7, in_rs1, in_rs2,
      input  out_ready, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      output in_ready, out_valid, gpr_wen, gpr_waddr, gpr_wdata, jump_en, dnpc, exc_misalign,
      output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask
   );

   // IDU / WBU / memory side
   modport master (
      output in_valid, in_pc, in_imm, in_op, in_rd, in_func3, in_func7, in_rs1, in_rs2,
      output out_ready, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      input  in_ready, out_valid, gpr_wen, gpr_waddr, gpr_wdata, jump_en, dnpc, exc_misalign,
      input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask
   );
endinterface

// File: rtl/ysyx_23060201_exu_mc.sv
// Multi-cycle execute / load-store unit: ALU, branches, jumps and byte-lane aligned
// memory access, one instruction in flight at a time.
//
//  state  | meaning
//  IDLE   | ready for an instruction; inputs latched on in_valid
//  EXEC   | compute result, next PC, effective address and misalignment
//  MREQ   | memory request held stable until mem_req_ready
//  MRSP   | waiting for mem_rsp_valid (load data or store ack)
//  DONE   | result presented to WBU until out_ready
module ysyx_23060201_exu_mc #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   ysyx_23060201_exu_mc_if.slave bus
);
   localparam int MASK_WIDTH = DATA_WIDTH / 8;
   localparam int OFF_W      = $clog2(MASK_WIDTH);
   localparam int SH_W       = $clog2(DATA_WIDTH);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;

   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MREQ, S_MRSP, S_DONE} state_t;
   state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_imm, r_rs1, r_rs2;
   logic [6:0]            r_op;
   logic [4:0]            r_rd;
   logic [2:0]            r_f3;
   logic                  r_f7b5;

   logic                  o_wen, o_jump, o_misalign;
   logic [DATA_WIDTH-1:0] o_wdata;
   logic [ADDR_WIDTH-1:0] o_dnpc;
   logic                  q_req_wen, q_is_load;
   logic [ADDR_WIDTH-1:0] q_req_addr;
   logic [DATA_WIDTH-1:0] q_req_wdata;
   logic [MASK_WIDTH-1:0] q_req_wmask;

   logic [ADDR_WIDTH-1:0] ea, pc4, pc_imm, nxt;
   logic [OFF_W-1:0]      off;
   logic                  is_ld, is_st, misalign, taken, jump, wen, mem_go;
   logic [DATA_WIDTH-1:0] opb, alu, res;
   logic [SH_W-1:0]       shamt;
   logic [MASK_WIDTH-1:0] base_mask;
   logic [DATA_WIDTH-1:0] ld_sh, ld_data;
   logic                  in_ready, out_valid, req_valid;

   always_comb begin
      ea     = ADDR_WIDTH'(r_rs1 + r_imm);
      off    = ea[OFF_W-1:0];
      pc4    = r_pc + ADDR_WIDTH'(4);
      pc_imm = r_pc + ADDR_WIDTH'(r_imm);
      is_ld  = (r_op == OP_LD);
      is_st  = (r_op == OP_ST);
      opb    = (r_op == OP_R) ? r_rs2 : r_imm;
      shamt  = opb[SH_W-1:0];

      alu = '0;
      case (r_f3)
         3'd0: alu = (r_op == OP_R && r_f7b5) ? r_rs1 - opb : r_rs1 + opb;
         3'd1: alu = r_rs1 << shamt;
         3'd2: alu = DATA_WIDTH'($signed(r_rs1) < $signed(opb));
         3'd3: alu = DATA_WIDTH'(r_rs1 < opb);
         3'd4: alu = r_rs1 ^ opb;
         3'd5: alu = r_f7b5 ? DATA_WIDTH'($signed(r_rs1) >>> shamt) : r_rs1 >> shamt;
         3'd6: alu = r_rs1 | opb;
         default: alu = r_rs1 & opb;
      endcase

      taken = 1'b0;
      case (r_f3)
         3'd0: taken = (r_rs1 == r_rs2);
         3'd1: taken = (r_rs1 != r_rs2);
         3'd4: taken = ($signed(r_rs1) < $signed(r_rs2));
         3'd5: taken = ($signed(r_rs1) >= $signed(r_rs2));
         3'd6: taken = (r_rs1 < r_rs2);
         3'd7: taken = (r_rs1 >= r_rs2);
         default: taken = 1'b0;
      endcase

      misalign = 1'b0;
      case (r_f3[1:0])
         2'd1: misalign = off[0];
         2'd2: misalign = (off[1:0] != 2'd0);
         2'd3: misalign = (off != '0);
         default: misalign = 1'b0;
      endcase
      misalign = misalign & (is_ld | is_st);
      mem_go   = (is_ld | is_st) & ~misalign;

      case (r_f3[1:0])
         2'd0: base_mask = MASK_WIDTH'(1);
         2'd1: base_mask = MASK_WIDTH'(3);
         2'd2: base_mask = MASK_WIDTH'(15);
         default: base_mask = MASK_WIDTH'(255);
      endcase

      res  = alu;
      wen  = 1'b0;
      jump = 1'b0;
      nxt  = pc4;
      case (r_op)
         OP_R, OP_I: wen = 1'b1;
         OP_LUI:   begin res = r_imm; wen = 1'b1; end
         OP_AUIPC: begin res = DATA_WIDTH'(pc_imm); wen = 1'b1; end
         OP_JAL:   begin res = DATA_WIDTH'(pc4); wen = 1'b1; jump = 1'b1; nxt = pc_imm; end
         OP_JALR:  begin
            res  = DATA_WIDTH'(pc4);
            wen  = 1'b1;
            jump = 1'b1;
            nxt  = {ea[ADDR_WIDTH-1:1], 1'b0};
         end
         OP_BR:    begin jump = taken; nxt = taken ? pc_imm : pc4; end
         OP_LD:    wen = ~misalign;
         default:  wen = 1'b0;
      endcase
      wen = wen & (r_rd != 5'd0);
   end

   // Memory returns the whole aligned word; move the addressed lane down first.
   always_comb begin
      ld_sh = bus.mem_rsp_rdata >> {q_req_addr[OFF_W-1:0], 3'b000};
      case (r_f3)
         3'b000:  ld_data = DATA_WIDTH'(signed'(ld_sh[7:0]));
         3'b001:  ld_data = DATA_WIDTH'(signed'(ld_sh[15:0]));
         3'b010:  ld_data = DATA_WIDTH'(signed'(ld_sh[31:0]));
         3'b100:  ld_data = DATA_WIDTH'(ld_sh[7:0]);
         3'b101:  ld_data = DATA_WIDTH'(ld_sh[15:0]);
         3'b110:  ld_data = DATA_WIDTH'(ld_sh[31:0]);
         default: ld_data = ld_sh;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      req_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) state_d = S_EXEC;
         end
         S_EXEC: state_d = mem_go ? S_MREQ : S_DONE;
         S_MREQ: begin
            req_valid = 1'b1;
            if (bus.mem_req_ready) state_d = S_MRSP;
         end
         S_MRSP: if (bus.mem_rsp_valid) state_d = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         r_pc        <= '0;
         r_imm       <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_op        <= '0;
         r_rd        <= '0;
         r_f3        <= '0;
         r_f7b5      <= 1'b0;
         o_wen       <= 1'b0;
         o_wdata     <= '0;
         o_jump      <= 1'b0;
         o_dnpc      <= '0;
         o_misalign  <= 1'b0;
         q_req_wen   <= 1'b0;
         q_req_addr  <= '0;
         q_req_wdata <= '0;
         q_req_wmask <= '0;
         q_is_load   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (bus.in_valid) begin
               r_pc   <= bus.in_pc;
               r_imm  <= bus.in_imm;
               r_rs1  <= bus.in_rs1;
               r_rs2  <= bus.in_rs2;
               r_op   <= bus.in_op;
               r_rd   <= bus.in_rd;
               r_f3   <= bus.in_func3;
               r_f7b5 <= bus.in_func7[5];
            end
            S_EXEC: begin
               o_wen       <= wen;
               o_wdata     <= res;
               o_jump      <= jump;
               o_dnpc      <= nxt;
               o_misalign  <= misalign;
               q_req_wen   <= is_st;
               q_req_addr  <= ea;
               q_req_wdata <= is_st ? r_rs2 << {off, 3'b000} : '0;
               q_req_wmask <= is_st ? base_mask << off : '0;
               q_is_load   <= is_ld;
            end
            S_MRSP: if (bus.mem_rsp_valid && q_is_load) o_wdata <= ld_data;
            default: ;
         endcase
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = out_valid;
   assign bus.gpr_wen       = o_wen;
   assign bus.gpr_waddr     = r_rd;
   assign bus.gpr_wdata     = o_wdata;
   assign bus.jump_en       = o_jump;
   assign bus.dnpc          = o_dnpc;
   assign bus.exc_misalign  = o_misalign;
   assign bus.mem_req_valid = req_valid;
   assign bus.mem_req_wen   = q_req_wen;
   assign bus.mem_req_addr  = q_req_addr;
   assign bus.mem_req_wdata = q_req_wdata;
   assign bus.mem_req_wmask = q_req_wmask;
endmodule

// File: tb/tb_ysyx_23060201_exu_mc.sv
// Directed bench for the multi-cycle EXU: ALU, branch/jump, load/store lanes,
// misalignment, memory/WBU stalls and async reset mid-transaction.
module tb_ysyx_23060201_exu_mc;
   localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LUI = 7'h37, OP_AUIPC = 7'h17;
   localparam logic [6:0] OP_JAL = 7'h6f, OP_JALR = 7'h67, OP_BR = 7'h63;
   localparam logic [6:0] OP_LD = 7'h03, OP_ST = 7'h23;

   typedef struct {
      logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic [4:0] rd;
      logic [31:0] rs1, rs2, imm, exp; logic wen;
   } alu_vec_t;
   typedef struct {
      logic [6:0] op; logic [2:0] f3; logic [4:0] rd; logic [31:0] pc, imm, rs1, rs2;
      logic jump; logic [31:0] dnpc; logic wen; logic [31:0] wdata;
   } br_vec_t;
   typedef struct {
      logic [6:0] op; logic [2:0] f3; logic [4:0] rd; logic [31:0] imm, rs2, rdata, addr;
      logic [3:0] mask; logic [31:0] rwdata; logic gwen; logic [31:0] gdata;
   } mem_vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_cmp = 0;
   int n_fail = 0;
   logic [73:0] obs, exp_v;

   always #5 clk = ~clk;

   ysyx_23060201_exu_mc_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
   ysyx_23060201_exu_mc #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_imm = '0; bus.in_op = '0;
      bus.in_rd = '0; bus.in_func3 = '0; bus.in_func7 = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
      bus.out_ready = 1'b0; bus.mem_req_ready = 1'b1;
      bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
   endtask

   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2);
      bus.in_op = op; bus.in_func3 = f3; bus.in_func7 = f7; bus.in_rd = rd;
      bus.in_pc = pc; bus.in_imm = imm; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic retire();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst_n = 1'b0;
      #12;
      obs   = {bus.out_valid, bus.gpr_wen, bus.gpr_waddr, bus.gpr_wdata, bus.jump_en,
               bus.dnpc, bus.exc_misalign};
      exp_v = '0;
      n_cmp++;
      if (obs !== exp_v) begin
         n_fail++; $display("FAIL reset_wb got=%h want=%h", obs, exp_v);
      end
      obs = {bus.mem_req_valid, bus.mem_req_wen, bus.mem_req_addr, bus.mem_req_wdata,
             bus.mem_req_wmask};
      n_cmp++;
      if (obs !== exp_v) begin
         n_fail++; $display("FAIL reset_mem got=%h want=%h", obs, exp_v);
      end
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
      end
   endtask

   task automatic test_alu();
      alu_vec_t v[11];
      v[0]  = '{OP_R,   3'd0, 7'h00, 5'd3,  32'd5,        32'd7,        32'd0,        32'd12,       1'b1};
      v[1]  = '{OP_R,   3'd0, 7'h20, 5'd4,  32'd5,        32'd7,        32'd0,        32'hFFFFFFFE, 1'b1};
      v[2]  = '{OP_I,   3'd5, 7'h20, 5'd5,  32'h80000000, 32'd0,        32'h00000404, 32'hF8000000, 1'b1};
      v[3]  = '{OP_I,   3'd5, 7'h00, 5'd6,  32'h80000000, 32'd0,        32'h00000004, 32'h08000000, 1'b1};
      v[4]  = '{OP_R,   3'd2, 7'h00, 5'd7,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd1,        1'b1};
      v[5]  = '{OP_R,   3'd3, 7'h00, 5'd8,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1'b1};
      v[6]  = '{OP_I,   3'd0, 7'h7F, 5'd9,  32'd10,       32'd0,        32'hFFFFFFFF, 32'd9,        1'b1};
      v[7]  = '{OP_R,   3'd4, 7'h00, 5'd0,  32'hF0,       32'h0F,       32'd0,        32'h0,        1'b0};
      v[8]  = '{OP_LUI, 3'd0, 7'h00, 5'd10, 32'd0,        32'd0,        32'h12345000, 32'h12345000, 1'b1};
      v[9]  = '{OP_AUIPC,3'd0,7'h00, 5'd11, 32'd0,        32'd0,        32'h00001000, 32'h80001000, 1'b1};
      v[10] = '{OP_R,   3'd1, 7'h00, 5'd12, 32'd1,        32'h21,       32'd0,        32'd2,        1'b1};
      for (int i = 0; i < 11; i++) begin
         issue(v[i].op, v[i].f3, v[i].f7, v[i].rd, 32'h80000000, v[i].imm, v[i].rs1, v[i].rs2);
         n_cmp++;
         if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL alu_early[%0d] out_valid got=%b want=0", i, bus.out_valid);
         end
         tick();
         obs   = {bus.out_valid, bus.gpr_wen, bus.gpr_waddr, v[i].wen ? bus.gpr_wdata : 32'h0,
                  bus.jump_en, bus.dnpc, bus.exc_misalign, bus.mem_req_valid};
         exp_v = {1'b1, v[i].wen, v[i].rd, v[i].wen ? v[i].exp : 32'h0,
                  1'b0, 32'h80000004, 1'b0, 1'b0};
         n_cmp++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL alu[%0d] got=%h want=%h", i, obs, exp_v);
         end
         retire();
      end
   endtask

   task automatic test_branch();
      br_vec_t v[9];
      v[0] = '{OP_BR,   3'd4, 5'd0, 32'h100, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'd1,        1'b1, 32'hF8,  1'b0, 32'h0};
      v[1] = '{OP_BR,   3'd6, 5'd0, 32'h100, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'd1,        1'b0, 32'h104, 1'b0, 32'h0};
      v[2] = '{OP_BR,   3'd0, 5'd5, 32'h100, 32'h10,       32'd5,        32'd5,        1'b1, 32'h110, 1'b0, 32'h0};
      v[3] = '{OP_BR,   3'd1, 5'd0, 32'h100, 32'h10,       32'd5,        32'd5,        1'b0, 32'h104, 1'b0, 32'h0};
      v[4] = '{OP_BR,   3'd5, 5'd0, 32'h100, 32'h10,       32'd1,        32'hFFFFFFFF, 1'b1, 32'h110, 1'b0, 32'h0};
      v[5] = '{OP_BR,   3'd7, 5'd0, 32'h100, 32'h10,       32'd1,        32'hFFFFFFFF, 1'b0, 32'h104, 1'b0, 32'h0};
      v[6] = '{OP_JAL,  3'd0, 5'd1, 32'h200, 32'h10,       32'd0,        32'd0,        1'b1, 32'h210, 1'b1, 32'h204};
      v[7] = '{OP_JALR, 3'd0, 5'd2, 32'h200, 32'h4,        32'h301,      32'd0,        1'b1, 32'h304, 1'b1, 32'h204};
      v[8] = '{7'h7F,   3'd0, 5'd5, 32'h300, 32'h40,       32'd1,        32'd2,        1'b0, 32'h304, 1'b0, 32'h0};
      for (int i = 0; i < 9; i++) begin
         issue(v[i].op, v[i].f3, 7'h00, v[i].rd, v[i].pc, v[i].imm, v[i].rs1, v[i].rs2);
         tick();
         obs   = {bus.out_valid, bus.gpr_wen, bus.gpr_waddr, v[i].wen ? bus.gpr_wdata : 32'h0,
                  bus.jump_en, bus.dnpc, bus.exc_misalign, bus.mem_req_valid};
         exp_v = {1'b1, v[i].wen, v[i].rd, v[i].wdata, v[i].jump, v[i].dnpc, 1'b0, 1'b0};
         n_cmp++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL branch[%0d] got=%h want=%h", i, obs, exp_v);
         end
         retire();
      end
   endtask

   task automatic test_mem();
      mem_vec_t v[9];
      logic st;
      v[0] = '{OP_ST, 3'd0, 5'd0, 32'd3, 32'h12345678, 32'h0,        32'h80000003, 4'h8, 32'h78000000, 1'b0, 32'h0};
      v[1] = '{OP_ST, 3'd1, 5'd0, 32'd2, 32'h12345678, 32'h0,        32'h80000002, 4'hC, 32'h56780000, 1'b0, 32'h0};
      v[2] = '{OP_ST, 3'd2, 5'd0, 32'd4, 32'hCAFEBABE, 32'h0,        32'h80000004, 4'hF, 32'hCAFEBABE, 1'b0, 32'h0};
      v[3] = '{OP_LD, 3'd1, 5'd5, 32'd2, 32'h0,        32'h80010000, 32'h80000002, 4'h0, 32'h0,        1'b1, 32'hFFFF8001};
      v[4] = '{OP_LD, 3'd5, 5'd6, 32'd2, 32'h0,        32'h80010000, 32'h80000002, 4'h0, 32'h0,        1'b1, 32'h00008001};
      v[5] = '{OP_LD, 3'd0, 5'd7, 32'd1, 32'h0,        32'h00008000, 32'h80000001, 4'h0, 32'h0,        1'b1, 32'hFFFFFF80};
      v[6] = '{OP_LD, 3'd4, 5'd8, 32'd3, 32'h0,        32'hAB000000, 32'h80000003, 4'h0, 32'h0,        1'b1, 32'h000000AB};
      v[7] = '{OP_LD, 3'd2, 5'd9, 32'd0, 32'h0,        32'h89ABCDEF, 32'h80000000, 4'h0, 32'h0,        1'b1, 32'h89ABCDEF};
      v[8] = '{OP_LD, 3'd2, 5'd0, 32'd4, 32'h0,        32'h11111111, 32'h80000004, 4'h0, 32'h0,        1'b0, 32'h0};
      for (int i = 0; i < 9; i++) begin
         st = (v[i].op == OP_ST);
         issue(v[i].op, v[i].f3, 7'h00, v[i].rd, 32'h80000000, v[i].imm, 32'h80000000, v[i].rs2);
         tick();
         obs   = {bus.mem_req_valid, bus.out_valid, bus.mem_req_wen, bus.mem_req_addr,
                  bus.mem_req_wmask, st ? bus.mem_req_wdata : 32'h0};
         exp_v = {1'b1, 1'b0, st, v[i].addr, v[i].mask, v[i].rwdata};
         n_cmp++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL mem_req[%0d] got=%h want=%h", i, obs, exp_v);
         end
         tick();
         n_cmp++;
         if ({bus.mem_req_valid, bus.out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL mem_rsp_wait[%0d] req/out got=%b%b want=00", i,
                     bus.mem_req_valid, bus.out_valid);
         end
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_rdata = v[i].rdata;
         tick();
         bus.mem_rsp_valid = 1'b0;
         obs   = {bus.out_valid, bus.gpr_wen, bus.gpr_waddr, v[i].gwen ? bus.gpr_wdata : 32'h0,
                  bus.jump_en, bus.dnpc, bus.exc_misalign, bus.mem_req_valid};
         exp_v = {1'b1, v[i].gwen, v[i].rd, v[i].gdata, 1'b0, 32'h80000004, 1'b0, 1'b0};
         n_cmp++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL mem_wb[%0d] got=%h want=%h", i, obs, exp_v);
         end
         retire();
      end
   endtask

   task automatic test_misalign();
      logic [6:0]  ops[4]  = '{OP_LD, OP_LD, OP_ST, OP_ST};
      logic [2:0]  f3s[4]  = '{3'd2, 3'd1, 3'd2, 3'd1};
      logic [31:0] imms[4] = '{32'd1, 32'd3, 32'd2, 32'd1};
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], f3s[i], 7'h00, 5'd5, 32'h80000000, imms[i], 32'h80000000, 32'h55AA55AA);
         n_cmp++;
         if (bus.mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL mis_req_exec[%0d] got=%b want=0", i, bus.mem_req_valid);
         end
         tick();
         obs   = {bus.out_valid, bus.mem_req_valid, bus.exc_misalign, bus.gpr_wen,
                  bus.jump_en, bus.dnpc};
         exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80000004};
         n_cmp++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL misalign[%0d] got=%h want=%h", i, obs, exp_v);
         end
         retire();
      end
   endtask

   task automatic test_stall_and_reset();
      issue(OP_ST, 3'd2, 7'h00, 5'd0, 32'h80000000, 32'd8, 32'h80000000, 32'hDEADBEEF);
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         obs   = {bus.mem_req_valid, bus.out_valid, bus.mem_req_wen, bus.mem_req_addr,
                  bus.mem_req_wmask, bus.mem_req_wdata};
         exp_v = {1'b1, 1'b0, 1'b1, 32'h80000008, 4'hF, 32'hDEADBEEF};
         n_cmp++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL req_stall[%0d] got=%h want=%h", c, obs, exp_v);
         end
      end
      bus.mem_rsp_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      tick();
      n_cmp++;
      if ({bus.mem_req_valid, bus.out_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL stall_mrsp req/out got=%b%b want=00", bus.mem_req_valid, bus.out_valid);
      end
      bus.mem_rsp_valid = 1'b1;
      tick();
      bus.mem_rsp_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         obs   = {bus.out_valid, bus.in_ready, bus.gpr_wen, bus.jump_en, bus.dnpc};
         exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 32'h80000004};
         n_cmp++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL out_stall[%0d] got=%h want=%h", c, obs, exp_v);
         end
         tick();
      end
      retire();
      n_cmp++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL stall_idle ready/valid got=%b%b want=10", bus.in_ready, bus.out_valid);
      end

      issue(OP_LD, 3'd2, 7'h00, 5'd4, 32'h80000000, 32'hC, 32'h80000000, 32'h0);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'h12345678;
      #1;
      obs   = {bus.in_ready, bus.out_valid, bus.mem_req_valid, bus.gpr_wen, bus.gpr_wdata,
               bus.dnpc, bus.exc_misalign};
      exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
         n_fail++; $display("FAIL async_reset got=%h want=%h", obs, exp_v);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if ({bus.in_ready, bus.out_valid, bus.mem_req_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL post_reset[%0d] ready/valid/req got=%b%b%b want=100", c,
                     bus.in_ready, bus.out_valid, bus.mem_req_valid);
         end
      end
      bus.mem_rsp_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      issue(OP_R, 3'd0, 7'h00, 5'd1, 32'h400, 32'd0, 32'd3, 32'd4);
      tick();
      issue_hold_next();
      obs   = {bus.out_valid, bus.gpr_wen, bus.gpr_waddr, bus.gpr_wdata, bus.dnpc};
      exp_v = {1'b1, 1'b1, 5'd1, 32'd7, 32'h404};
      n_cmp++;
      if (obs !== exp_v) begin
         n_fail++; $display("FAIL b2b_first got=%h want=%h", obs, exp_v);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      n_cmp++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_idle ready/valid got=%b%b want=10", bus.in_ready, bus.out_valid);
      end
      tick();
      bus.in_valid = 1'b0;
      tick();
      obs   = {bus.out_valid, bus.gpr_wen, bus.gpr_waddr, bus.gpr_wdata, bus.dnpc};
      exp_v = {1'b1, 1'b1, 5'd2, 32'hFFFFFFFF, 32'h504};
      n_cmp++;
      if (obs !== exp_v) begin
         n_fail++; $display("FAIL b2b_second got=%h want=%h", obs, exp_v);
      end
      retire();
   endtask

   // Presents the next instruction while the previous result is still in DONE.
   task automatic issue_hold_next();
      bus.in_op = OP_R; bus.in_func3 = 3'd0; bus.in_func7 = 7'h20; bus.in_rd = 5'd2;
      bus.in_pc = 32'h500; bus.in_imm = 32'd0; bus.in_rs1 = 32'd3; bus.in_rs2 = 32'd4;
      bus.in_valid = 1'b1;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout compared=%0d", n_cmp);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_mem();
      test_misalign();
      test_stall_and_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
